xy_pattern_gen: RTL and testbench
=================================

Name: xy_pattern_gen

Overview:
- Parametrised XY test-pattern source producing ADC-style X/Y/colour samples over a valid/ready handshake.
- Successor to the free-running x/y counter pair used to drive ADC inputs in display-pipeline benches and bring-up builds.
- Adds selectable patterns, programmable step, backpressure, frame-boundary mode switching and a frame_done pulse.
- Sits ahead of the ADC XY capture FIFO (sim or FPGA self-test).

Parameters:
- DATA_BITS, 10, width of each X/Y coordinate; MAX = 2**DATA_BITS-1.
- STEP_BITS, 4, width of step input.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- enable  input  1  permits new samples to be offered
- mode  input  2  pattern select, sampled only at frame boundaries
- step  input  STEP_BITS  coordinate increment per sample; 0 treated as 1
- out_valid  output  1  sample valid
- out_ready  input  1  consumer accepts sample
- out_x  output  DATA_BITS  X coordinate
- out_y  output  DATA_BITS  Y coordinate
- out_red, out_grn, out_blu  output  1 each  colour bits
- frame_done  output  1  one-cycle pulse on acceptance of a frame's last sample

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_x=0, out_y=0, frame_done=0, colours=1, active mode latched to 0 (RASTER), box edge=TOP.
- Accept = out_valid && out_ready. All state advances only on accept.
- out_valid rises the cycle after enable is sampled high. Once high, it stays high with x/y/colours stable until accept, regardless of enable. After an accept with enable low, out_valid drops next cycle.
- Throughput: one sample per cycle while out_ready=1.
- s = (step==0) ? 1 : step, zero-extended to DATA_BITS+1 for compares.
- Mode latch: the active mode loads from the mode input at reset release (value 0) and on each accept that pulses frame_done. Mid-frame mode changes are ignored.
- RASTER (0): x += s. If x > MAX-s, x <= 0 and y += s. If y also > MAX-s, y <= 0 and the frame ends.
- VRASTER (1): as RASTER with x and y swapped.
- BOX (2): perimeter of square 0..MAX. Edge FSM: TOP -> RIGHT -> BOTTOM -> LEFT -> TOP.
  - TOP: x up, y=0.
  - RIGHT: y up, x=MAX.
  - BOTTOM: x down, y=MAX.
  - LEFT: y down, x=0.
  - Each step clamps at the corner (MAX or 0); reaching the corner switches edge on the next accept.
  - Frame ends on the accept of (0,0) at the end of LEFT.
  - Corners are emitted exactly once.
- DIAG (3): x = y, both += s. Wrap to 0 when > MAX-s ends the frame.
- On a mode switch, coordinates restart at (0,0) with edge TOP.
- frame_done is registered and is high exactly in the cycle after the frame-ending accept.
- Arithmetic uses DATA_BITS+1 bits; outputs never exceed MAX.
- Step changes take effect on the next accept.

Optional Feature:
- XY_PATTERN_GEN_COLOR_EN defined:
  - {red,grn,blu} is a 3-bit counter, reset value 3'b111.
  - Advances on each frame end, sequence 111 -> 001 -> 010 -> ... -> 111, skipping 000.
- Undefined: colours are tied to 1.

Decomposition:
- xy_pattern_pkg:
  - mode enum typedef (RASTER, VRASTER, BOX, DIAG)
  - box edge enum typedef (TOP, RIGHT, BOTTOM, LEFT)
- Sub-module xy_axis_stepper:
  - One coordinate with step, up/down direction, and wrap/clamp select.
  - Outputs next value and at_limit flag.
  - Instantiated twice.

Test Plan:
- Reset with enable=1, mode=0, step=1, out_ready=1:
  - First sample (0,0) one cycle after enable sampled.
  - Samples (1,0), (2,0) follow; (1023,0) -> (0,1).
  - frame_done pulses once, after 1024*1024 accepts.
- Backpressure: hold out_ready=0 for 5 cycles at (7,3):
  - out_valid stays 1 and x/y stay (7,3).
  - Release -> next sample (8,3).
  - Also drop enable while stalled -> valid still held until accept.
- BOX, DATA_BITS=4, step=5:
  - Sequence (0,0),(5,0),(10,0),(15,0),(15,5),(15,10),(15,15),(10,15),(5,15),(0,15),(0,10),(0,5),(0,0)+frame_done.
- Mode change mid-frame (0 -> 3 at sample 100):
  - Raster continues to frame end.
  - Then DIAG from (0,0),(1,1).
- step=0 in DIAG, DATA_BITS=4:
  - 16 samples (0,0)..(15,15), then frame_done, then (0,0).
- With XY_PATTERN_GEN_COLOR_EN, RASTER, DATA_BITS=2, step=1:
  - Colours 111 during frame 0, 001 during frame 1, 010 during frame 2.
  - Async reset_n low mid-frame -> immediately out_valid=0, (0,0), colours 111.

Source files
------------

// File: rtl/xy_pattern_pkg.sv
// Shared types for the XY test-pattern generator: pattern modes and box-walk edges.
package xy_pattern_pkg;

    typedef enum logic [1:0] {
        RASTER  = 2'd0,
        VRASTER = 2'd1,
        BOX     = 2'd2,
        DIAG    = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        TOP    = 2'd0,
        RIGHT  = 2'd1,
        BOTTOM = 2'd2,
        LEFT   = 2'd3
    } box_edge_e;

endpackage

// File: rtl/xy_pattern_gen_if.sv
// Sample stream from the XY pattern generator toward the capture FIFO.
interface xy_pattern_gen_if #(
    parameter int DATA_BITS = 10
);
    logic                 out_valid;
    logic                 out_ready;
    logic [DATA_BITS-1:0] out_x;
    logic [DATA_BITS-1:0] out_y;
    logic                 out_red;
    logic                 out_grn;
    logic                 out_blu;
    logic                 frame_done;

    modport master (
        output out_valid, out_x, out_y, out_red, out_grn, out_blu, frame_done,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_x, out_y, out_red, out_grn, out_blu, frame_done,
        output out_ready
    );
endinterface

// File: rtl/xy_axis_stepper.sv
// One coordinate axis: proposes the next value for a given step and direction,
// either wrapping to 0 past MAX or clamping at the end of the range.
module xy_axis_stepper #(
    parameter int DATA_BITS = 10,
    parameter int AW        = 11
) (
    input  logic [DATA_BITS-1:0] cur,
    input  logic [AW-1:0]        step,
    input  logic                 down,
    input  logic                 wrap,
    output logic [DATA_BITS-1:0] nxt,
    output logic                 at_limit
);
    localparam logic [AW-1:0] MAX = AW'({DATA_BITS{1'b1}});

    logic [AW-1:0] cur_w;
    logic [AW-1:0] sum;
    logic          over;
    logic          under;

    // In wrap mode at_limit means "this step wraps"; in clamp mode it means
    // "already sitting on the corner".
    always_comb begin
        cur_w    = AW'(cur);
        sum      = cur_w + step;
        over     = (sum > MAX);
        under    = (cur_w < step);
        nxt      = '0;
        at_limit = 1'b0;
        if (down) begin
            nxt      = under ? '0 : DATA_BITS'(cur_w - step);
            at_limit = wrap ? under : (cur == '0);
        end else begin
            nxt      = over ? (wrap ? '0 : MAX[DATA_BITS-1:0]) : sum[DATA_BITS-1:0];
            at_limit = wrap ? over : (cur_w == MAX);
        end
    end
endmodule

// File: rtl/xy_pattern_gen.sv
// XY test-pattern source (raster, vertical raster, box perimeter, diagonal) over valid/ready.
// Define XY_PATTERN_GEN_COLOR_EN to step the colour bits once per frame.
module xy_pattern_gen
    import xy_pattern_pkg::*;
#(
    parameter int DATA_BITS = 10,
    parameter int STEP_BITS = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic [1:0]           mode,
    input  logic [STEP_BITS-1:0] step,
    xy_pattern_gen_if.master     bus
);
    localparam int AW = ((STEP_BITS > DATA_BITS) ? STEP_BITS : DATA_BITS) + 1;

    logic [DATA_BITS-1:0] x_q, y_q, x_d, y_d, x_nxt, y_nxt;
    logic                 x_lim, y_lim;
    logic                 valid_q, valid_d;
    logic                 frame_done_q, frame_end;
    logic                 accept;
    logic                 x_down, y_down, wrap;
    logic [AW-1:0]        s;
    logic [2:0]           colour_q;
    mode_e                mode_q, mode_d;
    box_edge_e            side_q, side_d;

    assign s      = (step == '0) ? AW'(1) : AW'(step);
    assign accept = valid_q && bus.out_ready;

    // Box walk: x descends when leaving RIGHT and along BOTTOM; y descends on BOTTOM->LEFT and LEFT.
    always_comb begin
        x_down = 1'b0;
        y_down = 1'b0;
        wrap   = 1'b1;
        if (mode_q == BOX) begin
            wrap   = 1'b0;
            x_down = (side_q == RIGHT) || (side_q == BOTTOM);
            y_down = (side_q == BOTTOM) || (side_q == LEFT);
        end
    end

    xy_axis_stepper #(.DATA_BITS(DATA_BITS), .AW(AW)) u_x_step (
        .cur(x_q), .step(s), .down(x_down), .wrap(wrap), .nxt(x_nxt), .at_limit(x_lim)
    );

    xy_axis_stepper #(.DATA_BITS(DATA_BITS), .AW(AW)) u_y_step (
        .cur(y_q), .step(s), .down(y_down), .wrap(wrap), .nxt(y_nxt), .at_limit(y_lim)
    );

    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        side_d    = side_q;
        mode_d    = mode_q;
        frame_end = 1'b0;
        valid_d   = (valid_q && !accept) || enable;
        if (accept) begin
            case (mode_q)
                RASTER: begin
                    x_d = x_nxt;
                    if (x_lim) begin
                        if (y_lim) frame_end = 1'b1;
                        else       y_d = y_nxt;
                    end
                end
                VRASTER: begin
                    y_d = y_nxt;
                    if (y_lim) begin
                        if (x_lim) frame_end = 1'b1;
                        else       x_d = x_nxt;
                    end
                end
                BOX: begin
                    case (side_q)
                        TOP:    if (x_lim) begin side_d = RIGHT;  y_d = y_nxt; end else x_d = x_nxt;
                        RIGHT:  if (y_lim) begin side_d = BOTTOM; x_d = x_nxt; end else y_d = y_nxt;
                        BOTTOM: if (x_lim) begin side_d = LEFT;   y_d = y_nxt; end else x_d = x_nxt;
                        LEFT:   if (y_lim) frame_end = 1'b1; else y_d = y_nxt;
                    endcase
                end
                DIAG: begin
                    if (x_lim) frame_end = 1'b1;
                    else begin
                        x_d = x_nxt;
                        y_d = x_nxt;
                    end
                end
            endcase
            // A new frame always restarts at the origin, so a mode switch needs no extra handling.
            if (frame_end) begin
                x_d    = '0;
                y_d    = '0;
                side_d = TOP;
                mode_d = mode_e'(mode);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q      <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            side_q       <= TOP;
            mode_q       <= RASTER;
            frame_done_q <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            x_q          <= x_d;
            y_q          <= y_d;
            side_q       <= side_d;
            mode_q       <= mode_d;
            frame_done_q <= frame_end;
        end
    end

`ifdef XY_PATTERN_GEN_COLOR_EN
    // 3-bit colour counter that skips 000 so some colour is always lit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)       colour_q <= 3'b111;
        else if (frame_end) colour_q <= (colour_q == 3'b111) ? 3'b001 : colour_q + 3'd1;
    end
`else
    assign colour_q = 3'b111;
`endif

    assign bus.out_valid  = valid_q;
    assign bus.out_x      = x_q;
    assign bus.out_y      = y_q;
    assign bus.frame_done = frame_done_q;
    assign {bus.out_red, bus.out_grn, bus.out_blu} = colour_q;
endmodule

// File: tb/tb_xy_pattern_gen.sv
// Bench for xy_pattern_gen: directed raster/backpressure on a 10-bit instance,
// directed raster/box/diag plus randomized traffic against a reference model on a 4-bit instance.
module tb_xy_pattern_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       b_rst_n, b_en, s_rst_n, s_en;
    logic [1:0] b_mode, s_mode;
    logic [3:0] b_step, s_step;

    xy_pattern_gen_if #(.DATA_BITS(10)) big_if();
    xy_pattern_gen_if #(.DATA_BITS(4))  sml_if();

    xy_pattern_gen #(.DATA_BITS(10), .STEP_BITS(4)) u_big (
        .clk(clk), .reset_n(b_rst_n), .enable(b_en), .mode(b_mode), .step(b_step), .bus(big_if.master)
    );

    xy_pattern_gen #(.DATA_BITS(4), .STEP_BITS(4)) u_sml (
        .clk(clk), .reset_n(s_rst_n), .enable(s_en), .mode(s_mode), .step(s_step), .bus(sml_if.master)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    // Reference model for the 4-bit instance, written directly from the pattern rules.
    localparam int SMAX = 15;
    int m_valid, m_x, m_y, m_edge, m_mode, m_col, m_fd;

    task automatic model_reset();
        m_valid = 0; m_x = 0; m_y = 0; m_edge = 0; m_mode = 0; m_col = 7; m_fd = 0;
    endtask

    task automatic model_step(input int en, input int md, input int st, input int rdy);
        int s, nx, ny;
        bit acc, fin;
        acc = (m_valid != 0) && (rdy != 0);
        fin = 0;
        if (acc) begin
            s = (st == 0) ? 1 : st;
            case (m_mode)
                0: begin
                    nx = m_x + s;
                    if (nx > SMAX) begin
                        m_x = 0; ny = m_y + s;
                        if (ny > SMAX) fin = 1; else m_y = ny;
                    end else m_x = nx;
                end
                1: begin
                    ny = m_y + s;
                    if (ny > SMAX) begin
                        m_y = 0; nx = m_x + s;
                        if (nx > SMAX) fin = 1; else m_x = nx;
                    end else m_y = ny;
                end
                2: begin
                    case (m_edge)
                        0: if (m_x == SMAX) begin m_edge = 1; m_y = (m_y + s > SMAX) ? SMAX : m_y + s; end
                           else m_x = (m_x + s > SMAX) ? SMAX : m_x + s;
                        1: if (m_y == SMAX) begin m_edge = 2; m_x = (m_x < s) ? 0 : m_x - s; end
                           else m_y = (m_y + s > SMAX) ? SMAX : m_y + s;
                        2: if (m_x == 0) begin m_edge = 3; m_y = (m_y < s) ? 0 : m_y - s; end
                           else m_x = (m_x < s) ? 0 : m_x - s;
                        default: if (m_y == 0) fin = 1; else m_y = (m_y < s) ? 0 : m_y - s;
                    endcase
                end
                default: begin
                    nx = m_x + s;
                    if (nx > SMAX) fin = 1; else begin m_x = nx; m_y = nx; end
                end
            endcase
            if (fin) begin
                m_x = 0; m_y = 0; m_edge = 0; m_mode = md;
`ifdef XY_PATTERN_GEN_COLOR_EN
                m_col = (m_col == 7) ? 1 : m_col + 1;
`endif
            end
        end
        m_valid = (m_valid != 0) ? (acc ? en : 1) : en;
        m_fd = fin;
    endtask

    task automatic big_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic sml_cyc();
        @(posedge clk);
        if (s_rst_n) model_step(s_en, s_mode, s_step, sml_if.out_ready);
        #1;
        check_val("s_valid", sml_if.out_valid, m_valid);
        check_val("s_x", sml_if.out_x, m_x);
        check_val("s_y", sml_if.out_y, m_y);
        check_val("s_frame_done", sml_if.frame_done, m_fd);
        check_val("s_colour", {sml_if.out_red, sml_if.out_grn, sml_if.out_blu}, m_col);
    endtask

    int rs_x[4]  = '{0, 15, 0, 15};
    int rs_y[4]  = '{0, 0, 15, 15};
    int bx_x[13] = '{0, 5, 10, 15, 15, 15, 15, 10, 5, 0, 0, 0, 0};
    int bx_y[13] = '{0, 0, 0, 0, 5, 10, 15, 15, 15, 15, 10, 5, 0};

    initial begin
        b_rst_n = 1'b0; b_en = 1'b1; b_mode = 2'd0; b_step = 4'd1; big_if.out_ready = 1'b1;
        s_rst_n = 1'b0; s_en = 1'b1; s_mode = 2'd2; s_step = 4'd15; sml_if.out_ready = 1'b1;
        model_reset();
        big_cyc(); big_cyc();
        check_val("rst_valid", big_if.out_valid, 0);
        check_val("rst_x", big_if.out_x, 0);
        check_val("rst_y", big_if.out_y, 0);
        check_val("rst_frame_done", big_if.frame_done, 0);
        check_val("rst_colour", {big_if.out_red, big_if.out_grn, big_if.out_blu}, 7);

        b_rst_n = 1'b1;
        big_cyc();
        check_val("first_valid", big_if.out_valid, 1);
        check_val("first_x", big_if.out_x, 0);
        check_val("first_y", big_if.out_y, 0);
        big_cyc();
        check_val("second_x", big_if.out_x, 1);
        big_cyc();
        check_val("third_x", big_if.out_x, 2);
        check_val("third_y", big_if.out_y, 0);
        for (int i = 0; i < 1021; i++) big_cyc();
        check_val("row_end_x", big_if.out_x, 1023);
        check_val("row_end_y", big_if.out_y, 0);
        big_cyc();
        check_val("row_wrap_x", big_if.out_x, 0);
        check_val("row_wrap_y", big_if.out_y, 1);
        check_val("row_wrap_fd", big_if.frame_done, 0);
        for (int i = 0; i < 2055; i++) big_cyc();
        check_val("stall_pt_x", big_if.out_x, 7);
        check_val("stall_pt_y", big_if.out_y, 3);

        big_if.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            big_cyc();
            if (i == 2) b_en = 1'b0;
            check_val("stall_valid", big_if.out_valid, 1);
            check_val("stall_x", big_if.out_x, 7);
            check_val("stall_y", big_if.out_y, 3);
        end
        big_cyc();
        check_val("stall_noen_valid", big_if.out_valid, 1);
        big_if.out_ready = 1'b1; b_en = 1'b1;
        big_cyc();
        check_val("release_x", big_if.out_x, 8);
        check_val("release_y", big_if.out_y, 3);
        check_val("release_valid", big_if.out_valid, 1);
        b_en = 1'b0;
        big_cyc();
        check_val("drop_valid", big_if.out_valid, 0);
        check_val("drop_x", big_if.out_x, 9);
        big_cyc();
        check_val("idle_valid", big_if.out_valid, 0);
        check_val("idle_x", big_if.out_x, 9);

        // 4-bit instance: raster with step 15 (mode input already BOX, latched only at frame end).
        s_rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sml_cyc();
            check_val("rs_x", sml_if.out_x, rs_x[i]);
            check_val("rs_y", sml_if.out_y, rs_y[i]);
        end
        sml_cyc();
        check_val("rs_frame_done", sml_if.frame_done, 1);
        s_step = 4'd5;
        check_val("bx_x", sml_if.out_x, bx_x[0]);
        check_val("bx_y", sml_if.out_y, bx_y[0]);
        for (int i = 1; i < 13; i++) begin
            sml_cyc();
            if (i == 5) s_mode = 2'd3;
            check_val("bx_x", sml_if.out_x, bx_x[i]);
            check_val("bx_y", sml_if.out_y, bx_y[i]);
            check_val("bx_no_fd", sml_if.frame_done, 0);
        end
        sml_cyc();
        check_val("bx_frame_done", sml_if.frame_done, 1);
        check_val("bx_restart_x", sml_if.out_x, 0);
        s_step = 4'd0;
        for (int i = 1; i < 16; i++) begin
            sml_cyc();
            check_val("dg_x", sml_if.out_x, i);
            check_val("dg_y", sml_if.out_y, i);
        end
        check_val("dg_no_fd", sml_if.frame_done, 0);
        sml_cyc();
        check_val("dg_frame_done", sml_if.frame_done, 1);
        check_val("dg_wrap_x", sml_if.out_x, 0);
        check_val("dg_wrap_y", sml_if.out_y, 0);
        sml_cyc();
        check_val("dg_next_x", sml_if.out_x, 1);
        check_val("dg_next_y", sml_if.out_y, 1);

        for (int c = 0; c < 4000; c++) begin
            s_en = ($urandom_range(0, 9) != 0);
            sml_if.out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 31) == 0) s_mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) s_step = 4'($urandom_range(0, 15));
            if (c == 2000) begin
                s_rst_n = 1'b0;
                #2;
                check_val("async_rst_valid", sml_if.out_valid, 0);
                check_val("async_rst_x", sml_if.out_x, 0);
                check_val("async_rst_y", sml_if.out_y, 0);
                check_val("async_rst_colour", {sml_if.out_red, sml_if.out_grn, sml_if.out_blu}, 7);
                model_reset();
                sml_cyc();
                s_rst_n = 1'b1;
            end
            sml_cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
